// File: rtl/alu_pkg.sv
// Shared ALU control codes, flag layout and control-code helpers.
// Imported by the ALU arbiter and its round-robin sub-module.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1011;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_NEG     = 2;
    localparam int FLAG_ILLEGAL = 3;

    typedef struct packed {
        logic illegal;
        logic negative;
        logic overflow;
        logic zero;
    } rsp_flags_t;

    function automatic logic is_legal_ctl(input logic [3:0] ctl);
        logic ok;
        ok = 1'b0;
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_XOR, ALU_NOR:
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only add/sub produce a meaningful overflow.
    function automatic logic ctl_has_ovf(input logic [3:0] ctl);
        return (ctl == ALU_ADD) || (ctl == ALU_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches req starting at ptr, wrapping.
// Ports: req, ptr in; grant (one-hot/zero), grant_idx, grant_any out.
module rr_arbiter #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = W'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU among NUM_REQ requesters, round-robin.
// Ports: req_* valid/ready in, alu_* to/from ALU, rsp_* per-requester out.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RR_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_op1,
    input  logic [NUM_REQ*32-1:0]  req_op2,
    input  logic [NUM_REQ*5-1:0]   req_shamt,
    input  logic [NUM_REQ*4-1:0]   req_ctl,
    output logic [31:0]            alu_op1,
    output logic [31:0]            alu_op2,
    output logic [4:0]             alu_shamt,
    output logic [3:0]             alu_ctl,
    input  logic [31:0]            alu_out,
    input  logic                   alu_zero,
    input  logic                   alu_overflow,
    input  logic                   alu_negative,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [NUM_REQ*32-1:0]  rsp_result,
    output logic [NUM_REQ*4-1:0]   rsp_flags
);

    logic [RR_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [RR_W-1:0]    grant_idx;
    logic               grant_any;
    logic [3:0]         cap_flags;

    // A full slot blocks its requester unless it drains this cycle;
    // nothing is granted while reset is asserted.
    assign eligible = req_valid
                    & (~rsp_valid | rsp_ready)
                    & {NUM_REQ{rst_n}};

    rr_arbiter #(
        .N (NUM_REQ),
        .W (RR_W)
    ) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + RR_W'(1);
            end
        end
    end

    // Idle drive is all-zero: AND of zeros gives a quiet result.
    always_comb begin
        alu_op1   = '0;
        alu_op2   = '0;
        alu_shamt = '0;
        alu_ctl   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_op1   = req_op1[i*32 +: 32];
                alu_op2   = req_op2[i*32 +: 32];
                alu_shamt = req_shamt[i*5 +: 5];
                alu_ctl   = req_ctl[i*4 +: 4];
            end
        end
    end

    always_comb begin
        cap_flags               = '0;
        cap_flags[FLAG_ZERO]    = alu_zero;
        cap_flags[FLAG_NEG]     = alu_negative;
        cap_flags[FLAG_OVF]     = alu_overflow & ctl_has_ovf(alu_ctl);
        cap_flags[FLAG_ILLEGAL] = ~is_legal_ctl(alu_ctl);
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        logic        v_q;
        logic [31:0] r_q;
        rsp_flags_t  f_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                r_q <= '0;
                f_q <= '0;
            end else if (grant[g]) begin
                v_q <= 1'b1;
                r_q <= alu_out;
                f_q <= rsp_flags_t'(cap_flags);
            end else if (rsp_ready[g]) begin
                v_q <= 1'b0;
            end
        end

        assign rsp_valid[g]          = v_q;
        assign rsp_result[g*32 +: 32] = r_q;
        assign rsp_flags[g*4 +: 4]    = f_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural shared ALU.
// Driver pushes expected responses on grant; monitor pops on handshake.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_op1 = '0;
    logic [N*32-1:0] req_op2 = '0;
    logic [N*5-1:0]  req_shamt = '0;
    logic [N*4-1:0]  req_ctl = '0;
    logic [31:0]     alu_op1, alu_op2, alu_out;
    logic [4:0]      alu_shamt;
    logic [3:0]      alu_ctl;
    logic            alu_zero, alu_overflow, alu_negative;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '1;
    logic [N*32-1:0] rsp_result;
    logic [N*4-1:0]  rsp_flags;

    int checks = 0;
    int failures = 0;

    logic [35:0] sb0[$];
    logic [35:0] sb1[$];
    logic [31:0] exp_res[N];
    logic [3:0]  exp_flg[N];

    alu_arbiter #(.NUM_REQ(N), .RR_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .req_shamt    (req_shamt),
        .req_ctl      (req_ctl),
        .alu_op1      (alu_op1),
        .alu_op2      (alu_op2),
        .alu_shamt    (alu_shamt),
        .alu_ctl      (alu_ctl),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags)
    );

    // Shared ALU model; raises a raw overflow on SLT too.
    logic [31:0] m_diff;
    always_comb begin
        alu_out      = '0;
        alu_overflow = 1'b0;
        m_diff       = alu_op1 - alu_op2;
        case (alu_ctl)
            ALU_AND: alu_out = alu_op1 & alu_op2;
            ALU_OR:  alu_out = alu_op1 | alu_op2;
            ALU_ADD: begin
                alu_out = alu_op1 + alu_op2;
                alu_overflow = (alu_op1[31] == alu_op2[31])
                             && (alu_out[31] != alu_op1[31]);
            end
            ALU_SUB: begin
                alu_out = m_diff;
                alu_overflow = (alu_op1[31] != alu_op2[31])
                             && (m_diff[31] != alu_op1[31]);
            end
            ALU_SLT: begin
                alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
                alu_overflow = (alu_op1[31] != alu_op2[31])
                             && (m_diff[31] != alu_op1[31]);
            end
            ALU_SLL: alu_out = alu_op2 << alu_shamt;
            ALU_SRL: alu_out = alu_op2 >> alu_shamt;
            ALU_SRA: alu_out = $signed(alu_op2) >>> alu_shamt;
            ALU_XOR: alu_out = alu_op1 ^ alu_op2;
            ALU_NOR: alu_out = ~(alu_op1 | alu_op2);
            default: alu_out = '0;
        endcase
        alu_zero     = (alu_out == 32'd0);
        alu_negative = alu_out[31];
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] s,
                           input logic [3:0] c, input logic [31:0] er,
                           input logic [3:0] ef);
        req_valid[i]         = 1'b1;
        req_op1[i*32 +: 32]  = a;
        req_op2[i*32 +: 32]  = b;
        req_shamt[i*5 +: 5]  = s;
        req_ctl[i*4 +: 4]    = c;
        exp_res[i]           = er;
        exp_flg[i]           = ef;
    endtask

    task automatic idle(input int i);
        req_valid[i] = 1'b0;
    endtask

    // Called right after a falling edge: checks grant, records expectations.
    task automatic step(input logic [N-1:0] exp_rdy, input string name);
        #1;
        chk(name, 64'(req_ready), 64'(exp_rdy));
        if (req_ready[0]) sb0.push_back({exp_res[0], exp_flg[0]});
        if (req_ready[1]) sb1.push_back({exp_res[1], exp_flg[1]});
    endtask

    // Monitor: compares on every response handshake, checks held data.
    logic [N-1:0] held = '0;
    logic [35:0]  prev[N];
    initial begin
        logic [35:0] e;
        logic        have;
        forever begin
            @(negedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (held[i] && rsp_valid[i]) begin
                    chk($sformatf("rsp%0d_hold", i),
                        64'({rsp_result[i*32 +: 32], rsp_flags[i*4 +: 4]}),
                        64'(prev[i]));
                end
                if (rsp_valid[i] && rsp_ready[i]) begin
                    have = 1'b0;
                    e    = '0;
                    if (i == 0 && sb0.size() != 0) begin
                        e = sb0.pop_front();
                        have = 1'b1;
                    end
                    if (i == 1 && sb1.size() != 0) begin
                        e = sb1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp%0d_unexpected actual=%0h required=none",
                                 i, rsp_result[i*32 +: 32]);
                    end else begin
                        chk($sformatf("rsp%0d_result", i),
                            64'(rsp_result[i*32 +: 32]), 64'(e[35:4]));
                        chk($sformatf("rsp%0d_flags", i),
                            64'(rsp_flags[i*4 +: 4]), 64'(e[3:0]));
                    end
                end
                held[i] = rsp_valid[i] & ~rsp_ready[i];
                prev[i] = {rsp_result[i*32 +: 32], rsp_flags[i*4 +: 4]};
            end
        end
    end

    initial begin
        // Reset with both requesters asserting: no grant allowed.
        set_req(0, 32'd1, 32'd2, 5'd0, ALU_ADD, 32'd3, 4'd0);
        set_req(1, 32'd1, 32'd2, 5'd0, ALU_ADD, 32'd3, 4'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_result", 64'(rsp_result), 64'd0);
        chk("rst_rsp_flags", 64'(rsp_flags), 64'd0);
        chk("rst_alu_ctl", 64'({alu_op1, alu_ctl}), 64'd0);

        // 1: single ADD
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 32'd5, 32'd7, 5'd0, ALU_ADD, 32'd12, 4'b0000);
        idle(1);
        step(2'b01, "t1_grant");
        @(negedge clk);
        idle(0);
        step(2'b00, "t1_idle");

        // 2: both requesting, pointer now at 1
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_req(0, 32'h0000F0F0, 32'h0000FF00, 5'd0, ALU_AND,
                    32'h0000F000, 4'b0000);
            set_req(1, 32'd3, 32'd5, 5'd0, ALU_SUB,
                    32'hFFFFFFFE, 4'b0100);
            step((k % 2 == 0) ? 2'b10 : 2'b01, $sformatf("t2_rr%0d", k));
        end
        @(negedge clk);
        idle(0);
        idle(1);
        step(2'b00, "t2_idle");

        // 3: overflow on ADD, masked on SLT
        @(negedge clk);
        set_req(0, 32'h7FFFFFFF, 32'd1, 5'd0, ALU_ADD,
                32'h80000000, 4'b0110);
        step(2'b01, "t3_add");
        @(negedge clk);
        set_req(0, 32'h80000000, 32'd1, 5'd0, ALU_SLT,
                32'd1, 4'b0000);
        step(2'b01, "t3_slt");
        @(negedge clk);
        idle(0);
        step(2'b00, "t3_idle");

        // 4: req1 slot blocked by back-pressure
        @(negedge clk);
        rsp_ready = 2'b01;
        set_req(1, 32'h0F, 32'hF0, 5'd0, ALU_OR, 32'hFF, 4'b0000);
        set_req(0, 32'hFF, 32'h0F, 5'd0, ALU_XOR, 32'hF0, 4'b0000);
        step(2'b10, "t4_first");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            step(2'b01, $sformatf("t4_block%0d", k));
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        step(2'b10, "t4_drain_grant");
        @(negedge clk);
        idle(0);
        idle(1);
        step(2'b00, "t4_idle");

        // 5: illegal code and shift
        @(negedge clk);
        set_req(0, 32'd5, 32'd7, 5'd0, 4'b0011, 32'd0, 4'b1001);
        step(2'b01, "t5_illegal");
        @(negedge clk);
        set_req(0, 32'd0, 32'd1, 5'd4, ALU_SLL, 32'h10, 4'b0000);
        step(2'b01, "t5_sll");
        @(negedge clk);
        idle(0);
        step(2'b00, "t5_idle");

        // 6: reset while a response is held and req1 pending
        @(negedge clk);
        rsp_ready = 2'b10;
        set_req(0, 32'd1, 32'd1, 5'd0, ALU_ADD, 32'd2, 4'b0000);
        step(2'b01, "t6_load");
        @(negedge clk);
        idle(0);
        set_req(1, 32'd10, 32'd20, 5'd0, ALU_ADD, 32'd30, 4'b0000);
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        step(2'b00, "t6_rst_ready");
        chk("t6_held_before_rst", 64'(rsp_valid), 64'b01);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 2'b11;
        set_req(0, 32'd7, 32'd8, 5'd0, ALU_ADD, 32'd15, 4'b0000);
        step(2'b01, "t6_ptr_reset");
        chk("t6_rsp_dropped", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        idle(0);
        step(2'b10, "t6_req1");
        @(negedge clk);
        idle(1);
        step(2'b00, "t6_idle");

        repeat (3) @(negedge clk);
        #3;
        chk("sb0_drained", 64'(sb0.size()), 64'd0);
        chk("sb1_drained", 64'(sb1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
